// File: rtl/uart_combine_ctrl.sv
// uart_combine_ctrl: register-bus controller sequencing the binary/8b10b UART datapath
module uart_combine_ctrl #(
  parameter logic [19:0] BAUD_RST = 20'd434,
  parameter int TX_START_TO = 16,
  parameter int TO_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        dp_data_ptr,
  output logic        dp_ctrl_ptr,
  output logic        dp_baud_ptr,
  output logic        dp_encode_ptr,
  output logic        dp_enable,
  output logic [6:0]  dp_ctrl,
  output logic [31:0] dp_data_out,
  output logic [19:0] dp_baud,
  input  logic        dp_tx_en,
  input  logic [9:0]  dp_bit_cnt,
  input  logic [31:0] dp_data_in,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, TX_LAUNCH, TX_WAIT, TX_BUSY, RX_ARM} state_t;
  state_t state, nxt;
  logic [TO_W-1:0] cnt;
  logic [7:0] tx_buf, rx_buf;
  logic ie_rx, ie_tx, rx_valid, tx_done, ovr, err, bc9_q;
  logic wr, rd, busy, a_data, a_ctrl, a_stat, a_baud, a_enc;
  logic tx_go, rx_go, abort, cap, timeout, done, bad;
  logic [4:0] w1c;
  logic [31:0] rmux;
  logic unused_bits;
  assign wr = bus_sel & bus_we;
  assign rd = bus_sel & ~bus_we;
  assign busy = state != IDLE;
  assign a_data = bus_addr == 5'h00;
  assign a_ctrl = bus_addr == 5'h08;
  assign a_stat = bus_addr == 5'h0C;
  assign a_baud = bus_addr == 5'h10;
  assign a_enc = bus_addr == 5'h14;
  assign tx_go = wr & a_ctrl & bus_wdata[0];
  assign rx_go = wr & a_ctrl & bus_wdata[1];
  assign abort = wr & a_ctrl & bus_wdata[2] & busy;
  // capture only on the rising edge of bit_cnt==9 so a long stop bit is not recaptured
  assign cap = state == RX_ARM && dp_bit_cnt == 10'd9 && !bc9_q && !abort;
  assign timeout = state == TX_WAIT && !dp_tx_en && cnt == TO_W'(TX_START_TO - 1) && !abort;
  assign done = state == TX_BUSY && !dp_tx_en && !abort;
  assign bad = (wr & busy & (a_data | a_baud | a_enc)) | (tx_go & rx_go) | ((tx_go | rx_go) & busy) | timeout;
  assign w1c = (wr & a_stat) ? bus_wdata[4:0] : 5'b0;
  assign rmux = a_data ? {24'b0, rx_buf} :
                a_ctrl ? {26'b0, ie_rx, ie_tx, 4'b0} :
                a_stat ? {27'b0, err, ovr, tx_done, rx_valid, busy} :
                a_baud ? {12'b0, dp_baud} :
                a_enc  ? {31'b0, dp_encode_ptr} : 32'b0;
  assign unused_bits = ^{dp_data_in[31:8], bus_wdata[31:20]};
  // next-state logic; abort overrides every busy state
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else case (state)
      IDLE:      nxt = tx_go ? TX_LAUNCH : rx_go ? RX_ARM : IDLE;
      TX_LAUNCH: nxt = TX_WAIT;
      TX_WAIT:   nxt = dp_tx_en ? TX_BUSY : timeout ? IDLE : TX_WAIT;
      TX_BUSY:   nxt = dp_tx_en ? TX_BUSY : IDLE;
      RX_ARM:    nxt = cap ? IDLE : RX_ARM;
      default:   nxt = IDLE;
    endcase
  end
  // state register, TX start timeout counter and bit_cnt edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bc9_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == TX_WAIT) ? cnt + 1'b1 : '0;
      bc9_q <= dp_bit_cnt == 10'd9;
    end
  end
  // datapath strobes registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_enable <= 1'b0;
      dp_data_ptr <= 1'b0;
      dp_ctrl <= 7'd0;
      dp_data_out <= 32'b0;
      dp_ctrl_ptr <= 1'b0;
      dp_baud_ptr <= 1'b0;
    end else begin
      dp_enable <= nxt != IDLE;
      dp_data_ptr <= nxt != IDLE;
      dp_ctrl <= nxt == RX_ARM ? 7'd2 : nxt == IDLE ? 7'd0 : 7'd1;
      dp_data_out <= (nxt == TX_LAUNCH || nxt == TX_WAIT || nxt == TX_BUSY) ? {24'b0, tx_buf} : 32'b0;
      dp_ctrl_ptr <= wr & a_ctrl;
      dp_baud_ptr <= wr & a_baud & ~busy;
    end
  end
  // configuration, buffers, sticky status, read port and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf <= 8'b0;
      rx_buf <= 8'b0;
      dp_baud <= BAUD_RST;
      dp_encode_ptr <= 1'b0;
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      rx_valid <= 1'b0;
      tx_done <= 1'b0;
      ovr <= 1'b0;
      err <= 1'b0;
      bus_rdata <= 32'b0;
      bus_rvalid <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr & a_data & ~busy) tx_buf <= bus_wdata[7:0];
      if (wr & a_baud & ~busy) dp_baud <= bus_wdata[19:0];
      if (wr & a_enc & ~busy) dp_encode_ptr <= bus_wdata[0];
      if (wr & a_ctrl) {ie_rx, ie_tx} <= bus_wdata[5:4];
      if (cap) rx_buf <= dp_data_in[7:0];
      rx_valid <= cap | (rx_valid & ~(rd & a_data) & ~w1c[1]);
      tx_done <= done | (tx_done & ~w1c[2]);
      ovr <= (cap & rx_valid) | (ovr & ~w1c[3]);
      err <= bad | (err & ~w1c[4]);
      bus_rdata <= rd ? rmux : 32'b0;
      bus_rvalid <= rd;
      irq <= (tx_done & ie_tx) | (rx_valid & ie_rx) | err;
    end
  end
endmodule
